// File: rtl/sike_arith_pkg.sv
// Shared SIKE field-arithmetic definitions: default operand/limb widths,
// limb-count helper and the serial multiplier FSM states.
package sike_arith_pkg;

  localparam int unsigned SIKE_W = 222;
  localparam int unsigned SIKE_L = 37;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  function automatic int unsigned limb_count(input int unsigned w, input int unsigned l);
    return (w + l - 1) / l;
  endfunction

endpackage

// File: rtl/serial_limb_multiplier_if.sv
// Start/done request bus of the serial limb multiplier.
interface serial_limb_multiplier_if
  import sike_arith_pkg::*;
#(
  parameter int unsigned W = SIKE_W
);

  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);

endinterface

// File: rtl/limb_mult.sv
// Unsigned L x L -> 2L combinational multiplier, kept separate so it maps onto DSP tiles.
module limb_mult #(
  parameter int unsigned L = 37
) (
  input  logic [L-1:0]   x,
  input  logic [L-1:0]   y,
  output logic [2*L-1:0] p_c
);

  assign p_c = (2*L)'(x) * (2*L)'(y);

endmodule

// File: rtl/serial_limb_multiplier.sv
// Full 2W-bit product of two W-bit operands, one L x L limb product per clock,
// accumulated with shift-add under a start/busy/done handshake.
module serial_limb_multiplier
  import sike_arith_pkg::*;
#(
  parameter int unsigned W = SIKE_W,
  parameter int unsigned L = SIKE_L
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_limb_multiplier_if.slave bus
);

  localparam int unsigned K  = limb_count(W, L);
  localparam int unsigned KL = K * L;
  localparam int unsigned AW = 2 * KL;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  mul_state_e    state_q, state_d;
  logic [CW-1:0] i_q, i_d, j_q, j_d;
  logic [KL-1:0] a_q, a_d, b_q, b_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [PW-1:0] product_q, product_d;
  logic          busy_q, busy_d, done_q, done_d;

  logic [L-1:0]   a_limb_c, b_limb_c;
  logic [2*L-1:0] pp_c;
  logic [AW-1:0]  pp_shift_c;

  assign a_limb_c   = a_q[32'(i_q) * L +: L];
  assign b_limb_c   = b_q[32'(j_q) * L +: L];
  assign pp_shift_c = AW'(pp_c) << (L * (32'(i_q) + 32'(j_q)));

  limb_mult #(.L(L)) u_limb_mult (
    .x   (a_limb_c),
    .y   (b_limb_c),
    .p_c (pp_c)
  );

  // Next state: j is the inner limb index, i the outer one.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_MUL;
          a_d     = KL'(bus.a);
          b_d     = KL'(bus.b);
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        acc_d = acc_q + pp_shift_c;
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            i_d       = '0;
            state_d   = ST_DONE;
            product_d = acc_d[PW-1:0];
          end else begin
            i_d = i_q + CW'(1);
          end
        end else begin
          j_d = j_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_MUL);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule
